// File: rtl/map_byte_sequencer_pkg.sv
// Shared definitions for the subcarrier-mapper front-end sequencer:
// FSM state encoding, modulation names, group sizing and pad-LFSR constants.
// Optional pad scrambling is controlled by the macro MAPSEQ_PRBS_PAD_EN.
package map_byte_sequencer_pkg;

   localparam int MAX_GROUP_BYTES = 8;
   localparam int GROUP_W         = 8 * MAX_GROUP_BYTES;

   // Modulation names carried as 6-character packed strings
   localparam logic [47:0] MOD_BPSK   = 48'("BPSK");
   localparam logic [47:0] MOD_QPSK   = 48'("QPSK");
   localparam logic [47:0] MOD_QAM16  = 48'("QAM16");
   localparam logic [47:0] MOD_QAM64  = 48'("QAM64");
   localparam logic [47:0] MOD_QAM256 = 48'("QAM256");

   // Pad LFSR x^7 + x^4 + 1: feedback taps on bits 6 and 3
   localparam logic [6:0] LFSR_TAPS = 7'b100_1000;
   localparam logic [6:0] LFSR_SEED = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_PAD   = 2'd3
   } seq_state_e;

   // Bytes consumed by one 8-subcarrier group for a given modulation
   function automatic int bytes_per_group(input logic [47:0] modulation);
      int result;
      result = 1;
      case (modulation)
         MOD_QPSK:   result = 2;
         MOD_QAM16:  result = 4;
         MOD_QAM64:  result = 6;
         MOD_QAM256: result = 8;
         default:    result = 1;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/map_pad_prbs.sv
// map_pad_prbs: pad-byte generator built on a 7-bit LFSR (x^7 + x^4 + 1).
// Present only when MAPSEQ_PRBS_PAD_EN is defined. Presents the next eight
// pad bytes at once (byte j = 8 generated bits, MSB first) and advances by
// however many of them the sequencer consumes this cycle.
`ifdef MAPSEQ_PRBS_PAD_EN
module map_pad_prbs
   import map_byte_sequencer_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               restart_i,
   input  logic [3:0]         advance_i,
   output logic [GROUP_W-1:0] pad_bytes_o
);

   logic [6:0] lfsr_q;
   logic [6:0] lfsr_d;
   logic [6:0] walk;
   logic       fb;

   // Unroll 64 LFSR steps from the current (or freshly seeded) state and pick the state after the consumed bytes
   always_comb begin
      walk        = restart_i ? LFSR_SEED : lfsr_q;
      lfsr_d      = walk;
      pad_bytes_o = '0;
      fb          = 1'b0;
      for (int j = 0; j < MAX_GROUP_BYTES; j++) begin
         for (int b = 0; b < 8; b++) begin
            fb                         = ^(walk & LFSR_TAPS);
            pad_bytes_o[8*j + 7 - b]   = fb;
            walk                       = {walk[5:0], fb};
         end
         if (advance_i == 4'(j + 1)) begin
            lfsr_d = walk;
         end
      end
   end

   // LFSR state register, reseeded on reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule
`endif

// File: rtl/map_byte_sequencer.sv
// map_byte_sequencer: packs a byte stream into 64-bit subcarrier-group words,
// pulses map_en once per group, pads the last OFDM frame of a packet out to
// whole groups, and emits group-aligned valid/first/last/pad markers.
// Define MAPSEQ_PRBS_PAD_EN to take pad bytes from an LFSR instead of zeros.
module map_byte_sequencer
   import map_byte_sequencer_pkg::*;
#(
   parameter logic [47:0] MODULATION       = MOD_BPSK,
   parameter int          GROUPS_PER_FRAME = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         in_byte,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   output logic               map_en,
   output logic [GROUP_W-1:0] map_data,
   output logic               out_valid,
   output logic               out_first,
   output logic               out_last,
   output logic               out_pad,
   output logic               busy
);

   localparam int                 N          = bytes_per_group(MODULATION);
   localparam logic [3:0]         N4         = 4'(N);
   localparam logic [7:0]         LAST_GROUP = 8'(GROUPS_PER_FRAME - 1);
   localparam logic [GROUP_W-1:0] GROUP_MASK = {GROUP_W{1'b1}} >> (GROUP_W - 8*N);

   seq_state_e         state_q;
   logic [3:0]         count_q;
   logic [7:0]         group_q;
   logic [GROUP_W-1:0] data_q;
   logic               padFlag_q;
   logic               pktEnded_q;
   logic               outValid_q;
   logic               outFirst_q;
   logic               outLast_q;
   logic               outPad_q;

   logic               xfer;
   logic               mapEnNow;
   logic               lastGroup;
   logic [3:0]         slotIdx;
   logic [3:0]         newCount;
   logic               groupDone;
   logic               padFill;
   logic [GROUP_W-1:0] keepMask;
   logic [GROUP_W-1:0] loadWord;
   logic [GROUP_W-1:0] padWord;
   logic [GROUP_W-1:0] padStream;

   assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign xfer      = in_valid && in_ready;
   assign mapEnNow  = (state_q == ST_ISSUE) || (state_q == ST_PAD);
   assign lastGroup = (group_q == LAST_GROUP);

   assign map_en    = mapEnNow;
   assign busy      = (state_q != ST_IDLE);
   assign map_data  = data_q;
   assign out_valid = outValid_q;
   assign out_first = outFirst_q;
   assign out_last  = outLast_q;
   assign out_pad   = outPad_q;

   // Build the group word that results from accepting in_byte, padding the tail when the packet ends short
   always_comb begin
      slotIdx   = (state_q == ST_IDLE) ? 4'd0 : count_q;
      newCount  = slotIdx + 4'd1;
      groupDone = (newCount == N4) || in_last;
      padFill   = in_last && (newCount < N4);
      keepMask  = ~({GROUP_W{1'b1}} << {newCount, 3'b000});
      loadWord  = data_q;
      loadWord[{slotIdx[2:0], 3'b000} +: 8] = in_byte;
      if (padFill) begin
         loadWord = (loadWord & keepMask) |
                    ((padStream << {newCount, 3'b000}) & GROUP_MASK);
      end
      padWord = padStream & GROUP_MASK;
   end

`ifdef MAPSEQ_PRBS_PAD_EN
   logic       padRestart;
   logic [3:0] padAdvance;

   // Reseed the pad generator at packet start and tell it how many pad bytes are consumed this cycle
   always_comb begin
      padRestart = xfer && (state_q == ST_IDLE);
      padAdvance = 4'd0;
      if (xfer && padFill) begin
         padAdvance = N4 - newCount;
      end else if ((state_q == ST_ISSUE) && pktEnded_q && !lastGroup) begin
         padAdvance = N4;
      end else if ((state_q == ST_PAD) && !lastGroup) begin
         padAdvance = N4;
      end
   end

   map_pad_prbs u_padPrbs (
      .clk_i       (clk),
      .rst_i       (rst),
      .restart_i   (padRestart),
      .advance_i   (padAdvance),
      .pad_bytes_o (padStream)
   );
`else
   assign padStream = '0;
`endif

   // Sequencer FSM: byte collection, group issue, frame padding and the registered downstream markers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         group_q    <= '0;
         data_q     <= '0;
         padFlag_q  <= 1'b0;
         pktEnded_q <= 1'b0;
         outValid_q <= 1'b0;
         outFirst_q <= 1'b0;
         outLast_q  <= 1'b0;
         outPad_q   <= 1'b0;
      end else begin
         outValid_q <= mapEnNow;
         outFirst_q <= mapEnNow && (group_q == 8'd0);
         outLast_q  <= mapEnNow && lastGroup;
         outPad_q   <= (state_q == ST_PAD) || ((state_q == ST_ISSUE) && padFlag_q);

         case (state_q)
            ST_IDLE, ST_LOAD: begin
               if (xfer) begin
                  data_q     <= loadWord;
                  count_q    <= newCount;
                  padFlag_q  <= padFill;
                  pktEnded_q <= in_last;
                  state_q    <= groupDone ? ST_ISSUE : ST_LOAD;
               end
            end
            ST_ISSUE: begin
               count_q   <= '0;
               padFlag_q <= 1'b0;
               group_q   <= lastGroup ? 8'd0 : group_q + 8'd1;
               if (!pktEnded_q) begin
                  state_q <= ST_LOAD;
               end else if (lastGroup) begin
                  state_q <= ST_IDLE;
               end else begin
                  data_q  <= padWord;
                  state_q <= ST_PAD;
               end
            end
            ST_PAD: begin
               group_q <= lastGroup ? 8'd0 : group_q + 8'd1;
               if (lastGroup) begin
                  state_q <= ST_IDLE;
               end else begin
                  data_q <= padWord;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_map_byte_sequencer.sv
// Directed self-checking bench for map_byte_sequencer. Five instances cover
// QPSK/QAM64/BPSK/QAM256/QAM16; inputs and reset are shared, and each test
// resets before driving the instance it examines.
module tb_map_byte_sequencer;
   import map_byte_sequencer_pkg::*;

   localparam int NDUT = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      inByte;
   logic            inValid;
   logic            inLast;
   logic [NDUT-1:0] inReady, mapEn, outValid, outFirst, outLast, outPad, busy;
   logic [63:0]     mapData [NDUT];

   int assertCount = 0;
   int failCount   = 0;
   int cycle       = 0;
   int dutSel      = 0;

   logic [63:0] enDataQ [$];
   int          enCycQ  [$];
   logic [2:0]  ovFlagQ [$];
   int          ovCycQ  [$];

   map_byte_sequencer #(.MODULATION(MOD_QPSK), .GROUPS_PER_FRAME(2)) u_dut0 (
      .clk(clk), .rst(rst), .in_byte(inByte), .in_valid(inValid), .in_last(inLast),
      .in_ready(inReady[0]), .map_en(mapEn[0]), .map_data(mapData[0]), .out_valid(outValid[0]),
      .out_first(outFirst[0]), .out_last(outLast[0]), .out_pad(outPad[0]), .busy(busy[0]));
   map_byte_sequencer #(.MODULATION(MOD_QAM64), .GROUPS_PER_FRAME(3)) u_dut1 (
      .clk(clk), .rst(rst), .in_byte(inByte), .in_valid(inValid), .in_last(inLast),
      .in_ready(inReady[1]), .map_en(mapEn[1]), .map_data(mapData[1]), .out_valid(outValid[1]),
      .out_first(outFirst[1]), .out_last(outLast[1]), .out_pad(outPad[1]), .busy(busy[1]));
   map_byte_sequencer #(.MODULATION(MOD_BPSK), .GROUPS_PER_FRAME(6)) u_dut2 (
      .clk(clk), .rst(rst), .in_byte(inByte), .in_valid(inValid), .in_last(inLast),
      .in_ready(inReady[2]), .map_en(mapEn[2]), .map_data(mapData[2]), .out_valid(outValid[2]),
      .out_first(outFirst[2]), .out_last(outLast[2]), .out_pad(outPad[2]), .busy(busy[2]));
   map_byte_sequencer #(.MODULATION(MOD_QAM256), .GROUPS_PER_FRAME(6)) u_dut3 (
      .clk(clk), .rst(rst), .in_byte(inByte), .in_valid(inValid), .in_last(inLast),
      .in_ready(inReady[3]), .map_en(mapEn[3]), .map_data(mapData[3]), .out_valid(outValid[3]),
      .out_first(outFirst[3]), .out_last(outLast[3]), .out_pad(outPad[3]), .busy(busy[3]));
   map_byte_sequencer #(.MODULATION(MOD_QAM16), .GROUPS_PER_FRAME(6)) u_dut4 (
      .clk(clk), .rst(rst), .in_byte(inByte), .in_valid(inValid), .in_last(inLast),
      .in_ready(inReady[4]), .map_en(mapEn[4]), .map_data(mapData[4]), .out_valid(outValid[4]),
      .out_first(outFirst[4]), .out_last(outLast[4]), .out_pad(outPad[4]), .busy(busy[4]));

   // Free-running clock
   always #5 clk = ~clk;

   // Count rising edges so event timing can be compared
   always @(posedge clk) cycle <= cycle + 1;

   // Log map_en words and out_valid markers of the selected instance
   always @(negedge clk) begin
      if (mapEn[dutSel]) begin
         enDataQ.push_back(mapData[dutSel]);
         enCycQ.push_back(cycle);
      end
      if (outValid[dutSel]) begin
         ovFlagQ.push_back({outFirst[dutSel], outLast[dutSel], outPad[dutSel]});
         ovCycQ.push_back(cycle);
      end
   end

   // Hard stop in case something hangs
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic clearLogs();
      enDataQ.delete();
      enCycQ.delete();
      ovFlagQ.delete();
      ovCycQ.delete();
   endtask

   task automatic applyReset();
      rst     = 1'b1;
      inValid = 1'b0;
      inLast  = 1'b0;
      inByte  = 8'h00;
      tick(2);
      clearLogs();
      rst = 1'b0;
   endtask

   task automatic applyStimulus(input int idx, input logic [7:0] b, input logic last);
      int waited;
      waited = 0;
      while (!inReady[idx] && waited < 20) begin
         tick();
         waited++;
      end
      checkOutput("in_ready before send", {63'd0, inReady[idx]}, 64'd1);
      inByte  = b;
      inValid = 1'b1;
      inLast  = last;
      tick();
      inValid = 1'b0;
      inLast  = 1'b0;
   endtask

   function automatic logic [63:0] enAt(input int k);
      return (k < enDataQ.size()) ? enDataQ[k] : 64'hDEAD_BEEF_DEAD_BEEF;
   endfunction

   function automatic logic [2:0] flagAt(input int k);
      return (k < ovFlagQ.size()) ? ovFlagQ[k] : 3'bxxx;
   endfunction

   function automatic int latencyAt(input int k);
      return (k < enCycQ.size() && k < ovCycQ.size()) ? ovCycQ[k] - enCycQ[k] : -1;
   endfunction

   function automatic int spacingAt(input int k);
      return (k + 1 < enCycQ.size()) ? enCycQ[k+1] - enCycQ[k] : -1;
   endfunction

`ifdef MAPSEQ_PRBS_PAD_EN
   // Reference pad stream: k-th byte generated from the 7'h7F seed
   function automatic logic [7:0] prbsByte(input int k);
      logic [6:0] s;
      logic [7:0] b;
      logic       nb;
      s = 7'h7F;
      b = 8'h00;
      for (int i = 0; i <= k; i++) begin
         for (int j = 0; j < 8; j++) begin
            nb = s[6] ^ s[3];
            b  = {b[6:0], nb};
            s  = {s[5:0], nb};
         end
      end
      return b;
   endfunction
`endif

   initial begin
      logic [63:0] exp1;
      logic [63:0] exp2;

      // Reset state of every instance
      rst = 1'b1; inValid = 1'b0; inLast = 1'b0; inByte = 8'h00;
      tick(2);
      checkOutput("reset map_en", {59'd0, mapEn}, 64'd0);
      checkOutput("reset out_valid", {59'd0, outValid}, 64'd0);
      checkOutput("reset markers", {59'd0, outFirst | outLast | outPad}, 64'd0);
      checkOutput("reset busy", {59'd0, busy}, 64'd0);
      checkOutput("reset map_data qpsk", mapData[0], 64'd0);
      checkOutput("reset map_data qam256", mapData[3], 64'd0);
      rst = 1'b0;
      tick();

      // QPSK, 2 groups per frame, 4 bytes
      dutSel = 0;
      applyReset();
      applyStimulus(0, 8'h11, 1'b0);
      applyStimulus(0, 8'h22, 1'b0);
      applyStimulus(0, 8'h33, 1'b0);
      applyStimulus(0, 8'h44, 1'b1);
      tick(4);
      checkOutput("qpsk map_en count", 64'(enDataQ.size()), 64'd2);
      checkOutput("qpsk group0 data", enAt(0), 64'h2211);
      checkOutput("qpsk group1 data", enAt(1), 64'h4433);
      checkOutput("qpsk out_valid count", 64'(ovFlagQ.size()), 64'd2);
      checkOutput("qpsk group0 first/last/pad", 64'(flagAt(0)), 64'b100);
      checkOutput("qpsk group1 first/last/pad", 64'(flagAt(1)), 64'b010);
      checkOutput("qpsk latency0", 64'(latencyAt(0)), 64'd1);
      checkOutput("qpsk latency1", 64'(latencyAt(1)), 64'd1);
      checkOutput("qpsk ends idle", {63'd0, busy[0]}, 64'd0);

      // QAM64, 3 groups per frame, 7 bytes: data, partial+pad, full pad
      dutSel = 1;
      applyReset();
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(1, 8'(k), (k == 7));
      end
      tick(5);
      exp1 = 64'h07;
      exp2 = 64'h0;
`ifdef MAPSEQ_PRBS_PAD_EN
      for (int k = 0; k < 5; k++) exp1[8*(k+1) +: 8] = prbsByte(k);
      for (int k = 0; k < 6; k++) exp2[8*k +: 8] = prbsByte(5 + k);
`endif
      checkOutput("qam64 map_en count", 64'(enDataQ.size()), 64'd3);
      checkOutput("qam64 group0 data", enAt(0), 64'h0000_0605_0403_0201);
      checkOutput("qam64 group1 data", enAt(1), exp1);
      checkOutput("qam64 group2 data", enAt(2), exp2);
      checkOutput("qam64 group0 first/last/pad", 64'(flagAt(0)), 64'b100);
      checkOutput("qam64 group1 first/last/pad", 64'(flagAt(1)), 64'b001);
      checkOutput("qam64 group2 first/last/pad", 64'(flagAt(2)), 64'b011);
      checkOutput("qam64 pad group spacing", 64'(spacingAt(1)), 64'd1);
      checkOutput("qam64 ends idle", {63'd0, busy[1]}, 64'd0);

      // BPSK with in_valid held high: ready alternates, one group every 2 cycles
      dutSel = 2;
      applyReset();
      for (int k = 0; k < 6; k++) begin
         checkOutput("bpsk in_ready pattern", {63'd0, inReady[2]}, ((k % 2) == 0) ? 64'd1 : 64'd0);
         inByte  = 8'hA0 + 8'(k);
         inValid = 1'b1;
         tick();
      end
      inValid = 1'b0;
      tick(2);
      checkOutput("bpsk group0 data", enAt(0), 64'hA0);
      checkOutput("bpsk group1 data", enAt(1), 64'hA2);
      checkOutput("bpsk group2 data", enAt(2), 64'hA4);
      checkOutput("bpsk map_en spacing", 64'(spacingAt(0)), 64'd2);
      checkOutput("bpsk latency0", 64'(latencyAt(0)), 64'd1);
      checkOutput("bpsk latency1", 64'(latencyAt(1)), 64'd1);
      checkOutput("bpsk first marker", 64'(flagAt(0)), 64'b100);

      // QAM256: reset after 5 bytes, then a fresh packet starts a new frame
      dutSel = 3;
      applyReset();
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(3, 8'(k), 1'b0);
      end
      checkOutput("qam256 busy mid-group", {63'd0, busy[3]}, 64'd1);
      rst = 1'b1;
      tick();
      checkOutput("qam256 reset map_en", {63'd0, mapEn[3]}, 64'd0);
      checkOutput("qam256 reset map_data", mapData[3], 64'd0);
      checkOutput("qam256 reset markers",
                  {60'd0, outValid[3], outFirst[3], outLast[3], outPad[3]}, 64'd0);
      checkOutput("qam256 reset busy", {63'd0, busy[3]}, 64'd0);
      rst = 1'b0;
      clearLogs();
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(3, 8'(k * 8'h11), (k == 8));
      end
      tick(10);
      checkOutput("qam256 group0 data", enAt(0), 64'h8877_6655_4433_2211);
      checkOutput("qam256 group0 first/last/pad", 64'(flagAt(0)), 64'b100);
      checkOutput("qam256 map_en count", 64'(enDataQ.size()), 64'd6);
      checkOutput("qam256 final pad group", 64'(flagAt(5)), 64'b011);

      // QAM16 backpressure: valid drops for 3 cycles mid-group
      dutSel = 4;
      applyReset();
      applyStimulus(4, 8'h10, 1'b0);
      applyStimulus(4, 8'h20, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("qam16 no map_en while stalled", {63'd0, mapEn[4]}, 64'd0);
      end
      applyStimulus(4, 8'h30, 1'b0);
      checkOutput("qam16 no map_en after 3rd byte", {63'd0, mapEn[4]}, 64'd0);
      applyStimulus(4, 8'h40, 1'b0);
      checkOutput("qam16 map_en after 4th byte", {63'd0, mapEn[4]}, 64'd1);
      checkOutput("qam16 byte order", mapData[4], 64'h4030_2010);

`ifdef MAPSEQ_PRBS_PAD_EN
      // QPSK single-byte packets: pad byte restarts from the seed every packet
      dutSel = 0;
      applyReset();
      applyStimulus(0, 8'h5A, 1'b1);
      tick(5);
      checkOutput("prbs pkt1 group0", enAt(0), 64'h0E5A);
      checkOutput("prbs pkt1 first/last/pad", 64'(flagAt(0)), 64'b101);
      clearLogs();
      applyStimulus(0, 8'h3C, 1'b1);
      tick(5);
      checkOutput("prbs pkt2 group0", enAt(0), 64'h0E3C);
      checkOutput("prbs pkt2 first/last/pad", 64'(flagAt(0)), 64'b101);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/map_byte_sequencer.md
Name: map_byte_sequencer

Overview:
Front-end controller for the subcarrier mapper. It accepts a byte stream over a valid/ready handshake and packs the bytes needed for one 8-subcarrier group (1/2/4/6/8 bytes for BPSK/QPSK/QAM16/QAM64/QAM256) into a 64-bit word. It pulses the mapper enable once per group and pads the last OFDM frame of a packet to a whole number of groups. It also produces group-aligned valid, first and last markers for the IFFT loader downstream.

Parameters:
MODULATION, "BPSK", one of BPSK/QPSK/QAM16/QAM64/QAM256; must match the mapper instance; sets N = bytes per group (1/2/4/6/8).
GROUPS_PER_FRAME, 6, number of 8-subcarrier groups per OFDM symbol (6 gives 48 data carriers); allowed range 1..255.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_byte  in  8  input data byte
in_valid  in  1  in_byte is valid
in_last  in  1  last byte of the packet; qualified by in_valid
in_ready  out  1  sequencer accepts in_byte this cycle
map_en  out  1  one-cycle enable to the mapper
map_data  out  64  packed group word; byte k occupies [8k+7:8k]; unused high bytes are 0
out_valid  out  1  mapper outputs are valid; map_en delayed by 1 cycle
out_first  out  1  with out_valid: first group of a frame
out_last  out  1  with out_valid: last group of a frame
out_pad  out  1  with out_valid: group contains at least one pad byte
busy  out  1  FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0, including map_data; state = IDLE; byte count = 0; group count = 0. A reset mid-packet discards any partial group and the frame position.
- Handshake: a byte transfers when in_valid & in_ready. in_ready is combinational from state only, never from in_valid.
- FSM states: IDLE, LOAD, ISSUE, PAD.
- IDLE:
  - in_ready = 1.
  - On a transfer: store the byte at slot 0, set count = 1, go to LOAD.
  - If N == 1, go to ISSUE directly.
- LOAD:
  - in_ready = 1.
  - Each transfer stores the byte at slot count and increments count.
  - When count reaches N: go to ISSUE.
  - When in_last is accepted with count < N: zero-fill the remaining slots, set the pad flag, go to ISSUE.
  - If in_last and count == N occur together: no pad in this group.
- ISSUE (exactly 1 cycle):
  - in_ready = 0; map_en = 1; map_data is stable.
  - Latch first = (group == 0), last = (group == GROUPS_PER_FRAME-1), and the pad flag for the out_* markers in the next cycle.
  - group increments and wraps to 0 after GROUPS_PER_FRAME-1.
  - count is cleared.
  - Next state:
    - packet not ended: LOAD;
    - packet ended and the group just issued was the last of its frame: IDLE;
    - packet ended, frame incomplete: PAD.
- PAD:
  - in_ready = 0.
  - Issue all-pad groups, one map_en every cycle, with out_pad = 1, until the frame's last group has been issued, then go to IDLE.
  - Pad bytes are 0 by default (see Optional Feature).
- Throughput: a data group takes N+1 cycles (N load cycles plus 1 issue cycle).
- Latency: map_en to out_valid is exactly 1 cycle. out_first, out_last and out_pad are registered alongside out_valid.
- Widths: byte count is 4 bits; group count is 8 bits.

Optional Feature:
MAPSEQ_PRBS_PAD_EN:
- When defined: pad bytes come from a 7-bit LFSR, x^7+x^4+1, seeded 7'h7F at reset and at every packet start. It advances 8 bits per pad byte, MSB first, and the pad byte is the 8 generated bits.
- When undefined: pad bytes are 8'h00, and no LFSR logic is present.

Decomposition:
- Shared package/header (alongside the existing OFDM common definitions): state encoding constants, the function bytes_per_group(MODULATION), MAX_GROUP_BYTES = 8, and the LFSR polynomial/seed constants.
- Natural sub-module: map_pad_prbs (the LFSR byte generator), instantiated only under MAPSEQ_PRBS_PAD_EN.

Test Plan:
- QPSK, GROUPS_PER_FRAME = 2; send 4 bytes 11,22,33,44 (in_last on 44):
  - map_en pulses with map_data = 0x2211, then 0x4433;
  - out_first on the 1st out_valid, out_last on the 2nd, out_pad = 0 throughout; ends in IDLE.
- QAM64, GROUPS_PER_FRAME = 3; send 7 bytes:
  - group 0 is data, pad = 0;
  - group 1 = byte 7 in slot 0, slots 1..5 = 0, pad = 1;
  - group 2 is an all-zero PAD group with out_last = 1.
- BPSK with in_valid held high:
  - in_ready toggles 1,0,1,0; one map_en every 2 cycles;
  - out_valid follows map_en by exactly 1 cycle.
- QAM256: assert rst after 5 bytes:
  - next cycle all outputs = 0 and busy = 0;
  - a fresh 8-byte packet then yields out_first = 1.
- Backpressure: deassert in_valid for 3 cycles mid-group in QAM16:
  - no map_en until the 4th byte arrives; map_data holds the correct byte order.
- MAPSEQ_PRBS_PAD_EN, QPSK, 1-byte packet:
  - slot 1 equals the first LFSR byte from seed 7'h7F;
  - a second packet repeats the identical pad byte.
